// File: rtl/bk_acc_pkg.sv
// Shared definitions for the bk_stream_acc accumulator slice.
// Holds the frame-state encoding, the datapath widths and the saturation
// constant used when the optional BK_ACC_SAT_EN build option is enabled.
package bk_acc_pkg;

    localparam int DATA_W = 32;
    localparam int SUM_W  = 33;

    // Value the accumulator is pinned to once it overflows (BK_ACC_SAT_EN builds).
    localparam logic [DATA_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/BrentKung32.sv
// BrentKung32: 32-bit Brent-Kung parallel-prefix adder with carry-in.
// Ports: in1/in2 operands, c0 carry-in, out = {carry-out, sum[31:0]}.
// Purely combinational (zero latency); no handshake, so no backpressure.
module BrentKung32 (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        c0,
    output logic [32:0] out
);

    // Prefix tree runs over 33 positions: position 0 is the carry-in,
    // position k (k >= 1) is operand bit k-1. After the tree, g[k] is the
    // carry into operand bit k, and g[32] is the carry-out.
    localparam int N = 33;

    logic [31:0]  gb;
    logic [31:0]  pb;
    logic [N-1:0] g;
    logic [N-1:0] p;

    assign gb = in1 & in2;
    assign pb = in1 ^ in2;

    always_comb begin
        g = {gb, c0};
        p = {pb, 1'b0};
        // Up-sweep: build group (g,p) over aligned power-of-two spans.
        for (int d = 0; d < 6; d++) begin
            for (int i = (2 << d) - 1; i < N; i += (2 << d)) begin
                g[6'(i)] = g[6'(i)] | (p[6'(i)] & g[6'(i - (1 << d))]);
                p[6'(i)] = p[6'(i)] & p[6'(i - (1 << d))];
            end
        end
        // Down-sweep: fill the remaining positions from completed prefixes.
        for (int d = 4; d >= 0; d--) begin
            for (int i = (2 << d) + (1 << d) - 1; i < N; i += (2 << d)) begin
                g[6'(i)] = g[6'(i)] | (p[6'(i)] & g[6'(i - (1 << d))]);
                p[6'(i)] = p[6'(i)] & p[6'(i - (1 << d))];
            end
        end
    end

    assign out = {g[N-1], pb ^ g[N-2:0]};

endmodule

// File: rtl/bk_stream_acc.sv
// bk_stream_acc: accumulates a valid/ready frame of 32-bit operands through
//   BrentKung32 and presents one registered {sum, carry count, beat count}.
// Latency: result valid the cycle after the last beat; one bubble after the
//   output handshake before the next frame can start.
// Backpressure: in_ready drops while a result waits; result held until out_ready.
//
// Ports: clk/rst (sync active-high); in_valid/in_ready/in_data/in_c0/in_last
//   operand stream; out_valid/out_ready/out_sum/out_carries/out_count result.
// Build option: BK_ACC_SAT_EN pins the accumulator at all-ones after the first
//   carry-out of a frame instead of wrapping.
module bk_stream_acc
    import bk_acc_pkg::*;
#(
    parameter int CW = 8,
    parameter int NW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_c0,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CW-1:0]     out_carries,
    output logic [NW-1:0]     out_count
);

    state_e            state_q;
    logic [DATA_W-1:0] acc_q,       acc_d;
    logic [CW-1:0]     carry_cnt_q, carry_cnt_d;
    logic [NW-1:0]     beat_cnt_q,  beat_cnt_d;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_sum_q;
    logic [CW-1:0]     out_carries_q;
    logic [NW-1:0]     out_count_q;
    logic [SUM_W-1:0]  add_out;
    logic              beat_acc;
    logic              out_hs;
`ifdef BK_ACC_SAT_EN
    logic              pin_q, pin_d;
`endif

    BrentKung32 u_adder (
        .in1 (acc_q),
        .in2 (in_data),
        .c0  (in_c0),
        .out (add_out)
    );

    // rst gates in_ready directly so a beat offered during reset is never
    // taken, even though state_q may still be mid-frame.
    assign in_ready = (state_q != DONE) && !rst;
    assign beat_acc = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    always_comb begin
        acc_d = add_out[DATA_W-1:0];
`ifdef BK_ACC_SAT_EN
        // Once pinned, the adder result is ignored for the rest of the frame
        // but its carry-out still feeds the carry counter below.
        pin_d = pin_q | add_out[DATA_W];
        if (pin_d) begin
            acc_d = SAT_VAL;
        end
`endif
        carry_cnt_d = carry_cnt_q;
        if (add_out[DATA_W] && (carry_cnt_q != '1)) begin
            carry_cnt_d = carry_cnt_q + 1'b1;
        end
        beat_cnt_d = beat_cnt_q;
        if (beat_cnt_q != '1) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            carry_cnt_q   <= '0;
            beat_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_carries_q <= '0;
            out_count_q   <= '0;
`ifdef BK_ACC_SAT_EN
            pin_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (beat_acc) begin
                        acc_q       <= acc_d;
                        carry_cnt_q <= carry_cnt_d;
                        beat_cnt_q  <= beat_cnt_d;
`ifdef BK_ACC_SAT_EN
                        pin_q       <= pin_d;
`endif
                        if (in_last) begin
                            // Capture the totals including this final beat.
                            state_q       <= DONE;
                            out_valid_q   <= 1'b1;
                            out_sum_q     <= acc_d;
                            out_carries_q <= carry_cnt_d;
                            out_count_q   <= beat_cnt_d;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (out_hs) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        carry_cnt_q <= '0;
                        beat_cnt_q  <= '0;
`ifdef BK_ACC_SAT_EN
                        pin_q       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign out_carries = out_carries_q;
    assign out_count   = out_count_q;

endmodule

// File: tb/tb_bk_stream_acc.sv
// Bench for bk_stream_acc: directed frames with literal expectations plus
// random frames, all cross-checked every cycle against a frame-level model.
module tb_bk_stream_acc;

    localparam int CW = 2;
    localparam int NW = 16;
    localparam int NFRAMES = 3000;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_c0;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_sum;
    logic [CW-1:0] out_carries;
    logic [NW-1:0] out_count;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 0;

    bk_stream_acc #(.CW(CW), .NW(NW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_c0       (in_c0),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carries (out_carries),
        .out_count   (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct {
        logic [31:0] sum;
        logic [63:0] car;
        logic [63:0] cnt;
    } res_t;

    res_t        exp_q[$];
    logic [63:0] m_tot;     // exact 64-bit running total of the frame
    int          m_cnt;
    logic [31:0] m_acc;     // used by the pinned-accumulator build only
    logic [63:0] m_car;
    bit          m_pin;

    function automatic logic [63:0] sat_car(input logic [63:0] c);
        logic [63:0] mx;
        mx = (64'd1 << CW) - 64'd1;
        return (c > mx) ? mx : c;
    endfunction

    always @(negedge clk) begin
        res_t r;
        logic [63:0] s;
        if (rst) begin
            chk("in_ready_in_rst", {63'd0, in_ready}, 64'd0);
            exp_q.delete();
            m_tot = 0; m_cnt = 0; m_acc = 0; m_car = 0; m_pin = 0;
        end else begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() == 0});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0 && out_valid) begin
                chk("out_sum", {32'd0, out_sum}, {32'd0, exp_q[0].sum});
                chk("out_carries", 64'(out_carries), exp_q[0].car);
                chk("out_count", 64'(out_count), exp_q[0].cnt);
                if (out_ready) void'(exp_q.pop_front());
            end else if (exp_q.size() == 0 && in_valid) begin
                m_tot = m_tot + 64'(in_data) + 64'(in_c0);
                m_cnt++;
`ifdef BK_ACC_SAT_EN
                s = 64'(m_acc) + 64'(in_data) + 64'(in_c0);
                if (s[32]) m_car++;
                m_pin = m_pin || s[32];
                m_acc = m_pin ? 32'hFFFF_FFFF : s[31:0];
`else
                // Every carry-out of a 32-bit wrap adds exactly one to the high word.
                m_acc = m_tot[31:0];
                m_car = m_tot >> 32;
`endif
                if (in_last) begin
                    r.sum = m_acc;
                    r.car = sat_car(m_car);
                    r.cnt = 64'(m_cnt);
                    exp_q.push_back(r);
                    m_tot = 0; m_cnt = 0; m_acc = 0; m_car = 0; m_pin = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic c, input logic l);
        int n;
        in_valid = 1'b1; in_data = d; in_c0 = c; in_last = l;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] s, input int c, input int n);
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_sum"}, {32'd0, out_sum}, {32'd0, s});
        chk({name, "_carries"}, 64'(out_carries), 64'(c));
        chk({name, "_count"}, 64'(out_count), 64'(n));
        chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        chk("post_hs_valid", {63'd0, out_valid}, 64'd0);
        chk("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_c0 = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum", {32'd0, out_sum}, 64'd0);
        chk("rst_out_carries", 64'(out_carries), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", {63'd0, in_ready}, 64'd1);

        // Single-beat frame: 0 + 0xA + 1.
        send_beat(32'h0000_000A, 1'b1, 1'b1);
        chk_out("one_beat", 32'h0000_000B, 0, 1);
        release_out();

        // Three-beat frame: 0x10 + 0x20 + 1 + 0x30.
        send_beat(32'h10, 1'b0, 1'b0);
        send_beat(32'h20, 1'b1, 1'b0);
        send_beat(32'h30, 1'b0, 1'b1);
        chk_out("three_beat", 32'h61, 0, 3);
        release_out();

        // Overflow across the 32-bit boundary.
        send_beat(32'hFFFF_FFFF, 1'b0, 1'b0);
        send_beat(32'h0000_0002, 1'b0, 1'b1);
`ifdef BK_ACC_SAT_EN
        chk_out("overflow", 32'hFFFF_FFFF, 1, 2);
`else
        chk_out("overflow", 32'h0000_0001, 1, 2);
`endif
        release_out();

        // Backpressure: result held, offered beat ignored.
        send_beat(32'h1, 1'b0, 1'b0);
        send_beat(32'h2, 1'b0, 1'b1);
        in_valid = 1'b1; in_data = 32'h99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_out("backpressure", 32'h3, 0, 2);
            tick();
        end
        in_valid = 1'b0;
        release_out();

        // Reset mid-frame discards the partial frame.
        send_beat(32'h5, 1'b0, 1'b0);
        send_beat(32'h7, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_sum", {32'd0, out_sum}, 64'd0);
        chk("midrst_out_count", 64'(out_count), 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        send_beat(32'h3, 1'b0, 1'b1);
        chk_out("after_rst", 32'h3, 0, 1);
        release_out();

        // Random frames against the model, random output backpressure.
        rand_rdy = 1;
        for (int f = 0; f < NFRAMES; f++) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                send_beat($urandom, 1'($urandom_range(0, 1)), b == len - 1);
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
        rand_rdy = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) tick();
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
